// File: rtl/piso_serializer_if.sv
// Parallel word handshake between an upstream producer and the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] Data;
    logic             Valid;
    logic             Ready;

    modport master (output Data, output Valid, input Ready);
    modport slave  (input Data, input Valid, output Ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: shifts a handshaken word out MSB first,
// with an optional idle gap between words.
module piso_serializer #(
    parameter int   WIDTH      = 4,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               Clk,
    input  logic               Rst,
    piso_serializer_if.slave   up,
    output logic               SerOut,
    output logic               Busy,
    output logic               FrameEnd
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [GW-1:0]    gcnt_q,  gcnt_d;
    logic             ser_q,   ser_d;
    logic             fend_q,  fend_d;
    logic             hs;

    assign up.Ready = (state_q == S_IDLE) ||
                      (state_q == S_SHIFT && cnt_q == '0 && GAP == 0);
    assign hs       = up.Valid && up.Ready;
    assign SerOut   = ser_q;
    assign FrameEnd = fend_q;
    assign Busy     = (state_q != S_IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            ser_q   <= IDLE_LEVEL;
            fend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            ser_q   <= ser_d;
            fend_q  <= fend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        ser_d   = ser_q;
        fend_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ser_d = IDLE_LEVEL;
                if (hs) begin
                    state_d = S_SHIFT;
                    sreg_d  = up.Data;
                    ser_d   = up.Data[WIDTH-1];
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d = sreg_q << 1;
                    ser_d  = sreg_q[WIDTH-2];
                    cnt_d  = cnt_q - 1'b1;
                    fend_d = (cnt_q == CW'(1));
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gcnt_d  = GW'(GAP - 1);
                    ser_d   = IDLE_LEVEL;
                end else if (hs) begin
                    // Back-to-back: the next MSB directly follows Data[0].
                    sreg_d = up.Data;
                    ser_d  = up.Data[WIDTH-1];
                    cnt_d  = CW'(WIDTH - 1);
                end else begin
                    state_d = S_IDLE;
                    ser_d   = IDLE_LEVEL;
                end
            end
            S_GAP: begin
                ser_d = IDLE_LEVEL;
                if (gcnt_q == '0) state_d = S_IDLE;
                else              gcnt_d  = gcnt_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = IDLE_LEVEL;
            end
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for three serializer configurations sharing one clock.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;
    logic serA, busyA, fendA;
    logic serB, busyB, fendB;
    logic serC, busyC, fendC;
    logic [3:0] dsr = '0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0] qA[$], qB[$], qC[$];
    logic [7:0] wA = '0, wB = '0, wC = '0;
    int unsigned remA = 0, remB = 0, remC = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) ifA ();
    piso_serializer_if #(.WIDTH(4)) ifB ();
    piso_serializer_if #(.WIDTH(8)) ifC ();

    piso_serializer #(.WIDTH(4), .GAP(0), .IDLE_LEVEL(1'b0)) dutA (
        .Clk(clk), .Rst(rstA), .up(ifA), .SerOut(serA), .Busy(busyA), .FrameEnd(fendA));
    piso_serializer #(.WIDTH(4), .GAP(2), .IDLE_LEVEL(1'b0)) dutB (
        .Clk(clk), .Rst(rstB), .up(ifB), .SerOut(serB), .Busy(busyB), .FrameEnd(fendB));
    piso_serializer #(.WIDTH(8), .GAP(0), .IDLE_LEVEL(1'b1)) dutC (
        .Clk(clk), .Rst(rstC), .up(ifC), .SerOut(serC), .Busy(busyC), .FrameEnd(fendC));

    // Downstream 4-bit serial-in shift register fed by instance A.
    always @(posedge clk) dsr <= {dsr[2:0], serA};

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rstA) remA = 0;
        else begin
            if (remA > 0) begin
                chk("A bit", 8'(serA), 8'(wA[remA-1]));
                chk("A frameend", 8'(fendA), 8'(remA == 1));
                chk("A busy", 8'(busyA), 8'd1);
                chk("A ready", 8'(ifA.Ready), 8'(remA == 1));
                remA--;
            end else begin
                chk("A idle serout", 8'(serA), 8'd0);
                chk("A idle frameend", 8'(fendA), 8'd0);
                chk("A idle busy", 8'(busyA), 8'd0);
            end
            if (ifA.Valid && ifA.Ready) begin
                if (qA.size() == 0) chk("A unexpected handshake", 8'd1, 8'd0);
                else begin wA = qA.pop_front(); remA = 4; end
            end
        end
    end

    always @(negedge clk) begin
        if (rstB) remB = 0;
        else begin
            if (remB > 0) begin
                chk("B bit", 8'(serB), 8'(wB[remB-1]));
                chk("B frameend", 8'(fendB), 8'(remB == 1));
                chk("B busy", 8'(busyB), 8'd1);
                chk("B ready", 8'(ifB.Ready), 8'd0);
                remB--;
            end else begin
                chk("B idle serout", 8'(serB), 8'd0);
                chk("B idle frameend", 8'(fendB), 8'd0);
                chk("B ready vs busy", 8'(ifB.Ready), 8'(!busyB));
            end
            if (ifB.Valid && ifB.Ready) begin
                if (qB.size() == 0) chk("B unexpected handshake", 8'd1, 8'd0);
                else begin wB = qB.pop_front(); remB = 4; end
            end
        end
    end

    always @(negedge clk) begin
        if (rstC) remC = 0;
        else begin
            if (remC > 0) begin
                chk("C bit", 8'(serC), 8'(wC[remC-1]));
                chk("C frameend", 8'(fendC), 8'(remC == 1));
                chk("C busy", 8'(busyC), 8'd1);
                chk("C ready", 8'(ifC.Ready), 8'(remC == 1));
                remC--;
            end else begin
                chk("C idle serout", 8'(serC), 8'd1);
                chk("C idle frameend", 8'(fendC), 8'd0);
                chk("C idle busy", 8'(busyC), 8'd0);
            end
            if (ifC.Valid && ifC.Ready) begin
                if (qC.size() == 0) chk("C unexpected handshake", 8'd1, 8'd0);
                else begin wC = qC.pop_front(); remC = 8; end
            end
        end
    end

    // Offer a word, wait (bounded) for Ready, complete the handshake.
    task automatic send(input int unsigned which, input logic [7:0] d, input bit keep,
                        output int unsigned waited);
        logic rdy;
        case (which)
            0: begin qA.push_back(d); ifA.Data = d[3:0]; ifA.Valid = 1'b1; end
            1: begin qB.push_back(d); ifB.Data = d[3:0]; ifB.Valid = 1'b1; end
            default: begin qC.push_back(d); ifC.Data = d; ifC.Valid = 1'b1; end
        endcase
        waited = 0;
        rdy = 1'b0;
        while (!rdy && waited < 64) begin
            @(negedge clk);
            rdy = (which == 0) ? ifA.Ready : (which == 1) ? ifB.Ready : ifC.Ready;
            if (!rdy) waited++;
        end
        if (!rdy) chk("handshake timeout", 8'd0, 8'd1);
        @(posedge clk);
        #1;
        if (!keep) begin
            case (which)
                0: ifA.Valid = 1'b0;
                1: ifB.Valid = 1'b0;
                default: ifC.Valid = 1'b0;
            endcase
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned w;
        ifA.Data = '0; ifA.Valid = 1'b0;
        ifB.Data = '0; ifB.Valid = 1'b0;
        ifC.Data = '0; ifC.Valid = 1'b0;
        idle(2);
        chk("reset A serout", 8'(serA), 8'd0);
        chk("reset A busy", 8'(busyA), 8'd0);
        chk("reset A frameend", 8'(fendA), 8'd0);
        chk("reset A ready", 8'(ifA.Ready), 8'd1);
        chk("reset B ready", 8'(ifB.Ready), 8'd1);
        chk("reset C serout", 8'(serC), 8'd1);
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        idle(2);

        // Single word, then the downstream register holds it after cycle 4.
        send(0, 8'h0B, 1'b0, w);
        chk("A single wait", 8'(w), 8'd0);
        idle(4);
        chk("downstream word", 8'(dsr), 8'h0B);
        idle(2);

        // Back-to-back: second word accepted in the last-bit cycle.
        send(0, 8'h0A, 1'b1, w);
        send(0, 8'h05, 1'b0, w);
        chk("A b2b wait", 8'(w), 8'd3);
        idle(6);

        // Data changes while busy; the word in flight is unaffected.
        send(0, 8'h09, 1'b1, w);
        send(0, 8'h06, 1'b0, w);
        chk("A stable wait", 8'(w), 8'd3);
        idle(6);

        // Reset mid-word: immediate abort, then a clean restart.
        send(0, 8'h0F, 1'b0, w);
        @(posedge clk);
        #3;
        rstA = 1'b1;
        #1;
        chk("async reset serout", 8'(serA), 8'd0);
        chk("async reset busy", 8'(busyA), 8'd0);
        chk("async reset frameend", 8'(fendA), 8'd0);
        @(posedge clk);
        #1;
        rstA = 1'b0;
        idle(1);
        send(0, 8'h01, 1'b0, w);
        idle(6);

        // Gap of two idle cycles: second handshake only in cycle 7.
        send(1, 8'h0C, 1'b1, w);
        send(1, 8'h03, 1'b0, w);
        chk("B gap wait", 8'(w), 8'd6);
        idle(8);

        // Wide word with idle level high.
        send(2, 8'hA5, 1'b0, w);
        idle(12);

        chk("A queue drained", 8'(qA.size() + remA), 8'd0);
        chk("B queue drained", 8'(qB.size() + remB), 8'd0);
        chk("C queue drained", 8'(qC.size() + remC), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock.
- Sits directly upstream of the 4-bit serial-in shift register and drives that register's serial input.
- With WIDTH=4, the downstream register's 4-bit output equals the sent word on the clock edge after the last bit has been presented.
- An optional idle gap between words lets downstream logic sample the assembled word.

Parameters:
WIDTH, 4, word length in bits (>=2)
GAP, 0, idle cycles inserted after each word (0 = back-to-back allowed)
IDLE_LEVEL, 0, SerOut level when not transmitting (1-bit)

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous, active-high reset
Data  in  WIDTH  parallel word, sampled only on handshake
Valid  in  1  upstream has a word on Data
Ready  out  1  block accepts Data this cycle (combinational from state)
SerOut  out  1  registered serial bit, feeds the shift register input
Busy  out  1  high in SHIFT or GAP state
FrameEnd  out  1  high in the cycle the word's last bit (Data[0]) is on SerOut

Behaviour:
- Interface: one clock, Clk. Reset Rst is asynchronous and active-high.
- Reset values: state=IDLE, SerOut=IDLE_LEVEL, FrameEnd=0, Busy=0, bit counter=0, gap counter=0, shift reg=0. Ready=1 (follows from IDLE).
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Ready=1, SerOut=IDLE_LEVEL.
  - On an edge with Valid&Ready: load the shift reg with Data, SerOut<=Data[WIDTH-1], cnt<=WIDTH-1, go to SHIFT.
- SHIFT:
  - Each edge with cnt>0: shift left, SerOut<=next bit, cnt<=cnt-1.
  - When cnt==0, SerOut holds Data[0] and FrameEnd=1 (registered alongside SerOut).
- Leaving SHIFT at the edge where cnt==0:
  - GAP>0: go to GAP, gap counter<=GAP-1, SerOut<=IDLE_LEVEL.
  - GAP==0 and Valid: Ready=1 in the cnt==0 cycle. Load the new word with no bubble; the next MSB follows Data[0] directly.
  - GAP==0 and no Valid: go to IDLE, SerOut<=IDLE_LEVEL.
- GAP:
  - Ready=0, SerOut=IDLE_LEVEL.
  - Count down; when the counter is 0, go to IDLE at the next edge.
- Ready = (state==IDLE) || (state==SHIFT && cnt==0 && GAP==0).
- Busy = (state!=IDLE).
- Latency: the MSB appears on SerOut one edge after the handshake. Data[0] appears WIDTH-1 edges after that.
- Data and Valid are ignored while Ready=0. Upstream must hold Valid until the handshake completes.
- Valid may drop without a handshake; no effect.
- Data changing during SHIFT has no effect on the word in flight.
- Reset mid-word: transmission aborts immediately (asynchronous). SerOut=IDLE_LEVEL, FrameEnd=0. No partial resumption after reset; the next word starts from IDLE.
- FrameEnd is a single-cycle pulse per word, including back-to-back words.
- Counter width: clog2(WIDTH) bits for cnt, clog2(GAP+1) bits for the gap counter (min 1). No wrap beyond these ranges.

Test Plan:
- Single word (WIDTH=4, GAP=0): Data=4'b1011, Valid pulse at cycle 0.
  -> SerOut=1,0,1,1 in cycles 1-4. FrameEnd=1 only in cycle 4. Busy=1 in cycles 1-4.
  -> Downstream shift register Out=4'b1011 after the edge ending cycle 4. SerOut=0 in cycle 5.
- Back-to-back (GAP=0): 4'hA then 4'h5 with Valid held high.
  -> SerOut=1,0,1,0,0,1,0,1 contiguous in cycles 1-8.
  -> Ready=1 in cycle 4. FrameEnd in cycles 4 and 8.
- Gap insertion (GAP=2): 4'hC then 4'h3, Valid held.
  -> Bits 1,1,0,0 in cycles 1-4, IDLE_LEVEL in cycles 5-6, IDLE in cycle 7 (Ready=1), handshake.
  -> 0,0,1,1 in cycles 8-11.
- Data stability: accept 4'h9, then change Data to 4'h6 while Busy with Valid high.
  -> SerOut=1,0,0,1 unaffected. 4'h6 is accepted only when Ready=1.
- Reset mid-word: accept 4'hF, assert Rst asynchronously between edges in cycle 2.
  -> SerOut=IDLE_LEVEL and Busy=0 immediately. No FrameEnd pulse.
  -> After Rst drops, the next word 4'h1 serializes as 0,0,0,1.
- WIDTH=8, IDLE_LEVEL=1: send 8'hA5.
  -> SerOut=1 before start. Bits 1,0,1,0,0,1,0,1 in cycles 1-8. FrameEnd in cycle 8. SerOut=1 in cycle 9.
